// File: rtl/conv_mem_pkg.sv
// Shared types and register helpers for the convolution accelerator memory path.
// The REGISTER_R / REGISTER_R_CE macros expect clk and rst (sync, active-high) in scope.
`ifndef CONV_MEM_REGISTERS_SVH
`define CONV_MEM_REGISTERS_SVH
`define REGISTER_R(q_r, d_s, rst_val) \
    always_ff @(posedge clk) begin \
        if (rst) q_r <= (rst_val); \
        else     q_r <= (d_s); \
    end
`define REGISTER_R_CE(q_r, d_s, ce_s, rst_val) \
    always_ff @(posedge clk) begin \
        if (rst)       q_r <= (rst_val); \
        else if (ce_s) q_r <= (d_s); \
    end
`endif

package conv_mem_pkg;

    localparam int LEN_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } arb_state_e;

    typedef enum logic {
        REQ_WT  = 1'b0,
        REQ_IFM = 1'b1
    } req_id_e;

    // Round-robin pick, returned one-hot as {ifm_win, wt_win}; a tie goes to
    // whichever requester was not served last.
    function automatic logic [1:0] rr_pick(input logic    wt_valid,
                                           input logic    ifm_valid,
                                           input req_id_e last_grant);
        logic [1:0] win;
        win = 2'b00;
        if (wt_valid && ifm_valid) begin
            if (last_grant == REQ_IFM) win = 2'b01;
            else                       win = 2'b10;
        end else begin
            win = {ifm_valid, wt_valid};
        end
        return win;
    endfunction

endpackage

// File: rtl/conv_burst_counter.sv
// Beat counter for one read burst: loads the burst length, counts down per
// accepted beat and flags the final beat.
module conv_burst_counter
    import conv_mem_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [LEN_W-1:0] load_val,
    input  logic             dec,
    output logic             last
);

    logic [LEN_W-1:0] cnt_r;
    logic [LEN_W-1:0] cnt_d_s;
    logic             cnt_ce_s;

    // Load has priority; a load and a beat never coincide in practice.
    always_comb begin
        cnt_d_s = cnt_r;
        if (load) begin
            cnt_d_s = load_val;
        end else if (dec) begin
            cnt_d_s = cnt_r - {{(LEN_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d_s = cnt_r;
        end
        cnt_ce_s = load | dec;
    end

    // Beat counter register
    `REGISTER_R_CE(cnt_r, cnt_d_s, cnt_ce_s, {LEN_W{1'b0}})

    assign last = (cnt_r == {{(LEN_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/conv_rd_arbiter.sv
// Round-robin arbiter sharing one burst-read memory channel between the weight
// (WT) and input-feature-map (IFM) fetchers, with per-burst beat steering.
module conv_rd_arbiter
    import conv_mem_pkg::*;
#(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32
)
(
    input  logic              clk,
    input  logic              rst,

    input  logic              wt_req_valid,
    output logic              wt_req_ready,
    input  logic [AWIDTH-1:0] wt_req_addr,
    input  logic [LEN_W-1:0]  wt_req_len,
    output logic [DWIDTH-1:0] wt_dout,
    output logic              wt_dout_valid,
    input  logic              wt_dout_ready,
    output logic              wt_done,

    input  logic              ifm_req_valid,
    output logic              ifm_req_ready,
    input  logic [AWIDTH-1:0] ifm_req_addr,
    input  logic [LEN_W-1:0]  ifm_req_len,
    output logic [DWIDTH-1:0] ifm_dout,
    output logic              ifm_dout_valid,
    input  logic              ifm_dout_ready,
    output logic              ifm_done,

    output logic              req_read_addr_valid,
    input  logic              req_read_addr_ready,
    output logic [AWIDTH-1:0] req_read_addr,
    output logic [LEN_W-1:0]  req_read_len,
    input  logic [DWIDTH-1:0] req_read_data,
    input  logic              req_read_data_valid,
    output logic              req_read_data_ready
);

    arb_state_e        state_r;
    arb_state_e        state_d_s;
    req_id_e           grant_r;
    req_id_e           last_grant_r;
    req_id_e           last_grant_d_s;
    req_id_e           win_id_s;
    logic [AWIDTH-1:0] addr_r;
    logic [AWIDTH-1:0] sel_addr_s;
    logic [LEN_W-1:0]  len_r;
    logic [LEN_W-1:0]  sel_len_s;
    logic [1:0]        win_s;
    logic              accept_s;
    logic              zero_len_s;
    logic              last_grant_ce_s;
    logic              owner_ready_s;
    logic              addr_fire_s;
    logic              data_fire_s;
    logic              cnt_last_s;
    logic              burst_end_s;

    // Winner selection; only IDLE accepts new requests
    always_comb begin
        win_s = 2'b00;
        if (state_r == ST_IDLE) begin
            win_s = rr_pick(wt_req_valid, ifm_req_valid, last_grant_r);
        end else begin
            win_s = 2'b00;
        end
        accept_s = |win_s;
        if (win_s[1]) begin
            win_id_s   = REQ_IFM;
            sel_addr_s = ifm_req_addr;
            sel_len_s  = ifm_req_len;
        end else begin
            win_id_s   = REQ_WT;
            sel_addr_s = wt_req_addr;
            sel_len_s  = wt_req_len;
        end
        zero_len_s = accept_s && (sel_len_s == {LEN_W{1'b0}});
    end

    // Handshake decode for the address and data phases
    always_comb begin
        owner_ready_s = (grant_r == REQ_IFM) ? ifm_dout_ready : wt_dout_ready;
        addr_fire_s   = (state_r == ST_ADDR) && req_read_addr_ready;
        data_fire_s   = (state_r == ST_DATA) && req_read_data_valid && owner_ready_s;
        burst_end_s   = data_fire_s && cnt_last_s;
    end

    // Next-state logic; zero-length bursts complete without leaving IDLE
    always_comb begin
        state_d_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && !zero_len_s) state_d_s = ST_ADDR;
                else                         state_d_s = ST_IDLE;
            end
            ST_ADDR: begin
                if (addr_fire_s) state_d_s = ST_DATA;
                else             state_d_s = ST_ADDR;
            end
            ST_DATA: begin
                if (burst_end_s) state_d_s = ST_IDLE;
                else             state_d_s = ST_DATA;
            end
            default: state_d_s = ST_IDLE;
        endcase
        last_grant_ce_s = zero_len_s | burst_end_s;
        if (zero_len_s) last_grant_d_s = win_id_s;
        else            last_grant_d_s = grant_r;
    end

    // Output decode; beats are only taken from memory during DATA
    always_comb begin
        wt_req_ready        = win_s[0];
        ifm_req_ready       = win_s[1];
        req_read_addr_valid = (state_r == ST_ADDR);
        req_read_addr       = addr_r;
        req_read_len        = len_r;
        req_read_data_ready = (state_r == ST_DATA) && owner_ready_s;
        wt_dout             = req_read_data;
        ifm_dout            = req_read_data;
        wt_dout_valid       = (state_r == ST_DATA) && (grant_r == REQ_WT) && req_read_data_valid;
        ifm_dout_valid      = (state_r == ST_DATA) && (grant_r == REQ_IFM) && req_read_data_valid;
        wt_done             = (zero_len_s && win_s[0]) || (burst_end_s && (grant_r == REQ_WT));
        ifm_done            = (zero_len_s && win_s[1]) || (burst_end_s && (grant_r == REQ_IFM));
    end

    // FSM state register
    `REGISTER_R(state_r, state_d_s, ST_IDLE)
    // Current burst owner
    `REGISTER_R_CE(grant_r, win_id_s, accept_s, REQ_WT)
    // Last completed owner; reset to IFM so WT wins the first tie
    `REGISTER_R_CE(last_grant_r, last_grant_d_s, last_grant_ce_s, REQ_IFM)
    // Latched burst address
    `REGISTER_R_CE(addr_r, sel_addr_s, accept_s, {AWIDTH{1'b0}})
    // Latched burst length
    `REGISTER_R_CE(len_r, sel_len_s, accept_s, {LEN_W{1'b0}})

    conv_burst_counter u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (addr_fire_s),
        .load_val (len_r),
        .dec      (data_fire_s),
        .last     (cnt_last_s)
    );

endmodule

// File: tb/tb_conv_rd_arbiter.sv
// Self-checking bench for conv_rd_arbiter: arbitration vector table, directed
// multi-cycle sequences, and randomized traffic against a transaction-level model.
module tb_conv_rd_arbiter;

    logic        clk;
    logic        rst;
    logic        wt_req_valid, wt_req_ready, wt_dout_valid, wt_dout_ready, wt_done;
    logic [31:0] wt_req_addr, wt_req_len, wt_dout;
    logic        ifm_req_valid, ifm_req_ready, ifm_dout_valid, ifm_dout_ready, ifm_done;
    logic [31:0] ifm_req_addr, ifm_req_len, ifm_dout;
    logic        req_read_addr_valid, req_read_addr_ready;
    logic [31:0] req_read_addr, req_read_len, req_read_data;
    logic        req_read_data_valid, req_read_data_ready;

    conv_rd_arbiter #(.AWIDTH(32), .DWIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .wt_req_valid(wt_req_valid), .wt_req_ready(wt_req_ready),
        .wt_req_addr(wt_req_addr), .wt_req_len(wt_req_len),
        .wt_dout(wt_dout), .wt_dout_valid(wt_dout_valid),
        .wt_dout_ready(wt_dout_ready), .wt_done(wt_done),
        .ifm_req_valid(ifm_req_valid), .ifm_req_ready(ifm_req_ready),
        .ifm_req_addr(ifm_req_addr), .ifm_req_len(ifm_req_len),
        .ifm_dout(ifm_dout), .ifm_dout_valid(ifm_dout_valid),
        .ifm_dout_ready(ifm_dout_ready), .ifm_done(ifm_done),
        .req_read_addr_valid(req_read_addr_valid), .req_read_addr_ready(req_read_addr_ready),
        .req_read_addr(req_read_addr), .req_read_len(req_read_len),
        .req_read_data(req_read_data), .req_read_data_valid(req_read_data_valid),
        .req_read_data_ready(req_read_data_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        else n_pass++;
    endtask

    typedef struct {
        logic        wv;
        logic        iv;
        logic [31:0] wl;
        logic [31:0] il;
        logic [3:0]  exp;   // {wt_req_ready, ifm_req_ready, wt_done, ifm_done}
    } vec_t;
    vec_t tbl[8];

    typedef struct {
        logic [31:0] a;
        logic [31:0] l;
    } burst_t;

    // Transaction-level model state (0 = WT, 1 = IFM)
    bit          m_busy, m_addr_wait;
    int          m_owner, m_last;
    logic [31:0] m_cur_addr, m_cur_len, m_beat;
    bit          pend[2];
    logic [31:0] pend_addr[2], pend_len[2];
    logic        dready[2];
    burst_t      mq[$];
    logic [31:0] midx;
    int          grants[$];

    int          beats, dones, done_at;
    bit          flag, vals_ok;
    logic [7:0]  go;

    task automatic idle_inputs();
        wt_req_valid = 1'b0; wt_req_addr = 32'd0; wt_req_len = 32'd0; wt_dout_ready = 1'b0;
        ifm_req_valid = 1'b0; ifm_req_addr = 32'd0; ifm_req_len = 32'd0; ifm_dout_ready = 1'b0;
        req_read_addr_ready = 1'b0; req_read_data = 32'd0; req_read_data_valid = 1'b0;
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_addr_wait = 1'b0; m_owner = 0; m_last = 1;
        m_cur_addr = 32'd0; m_cur_len = 32'd0; m_beat = 32'd0; midx = 32'd0;
        pend[0] = 1'b0; pend[1] = 1'b0;
        mq.delete(); grants.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // One cycle of model checking, run #1 after inputs for the cycle are applied.
    task automatic model_step();
        int          win;
        logic [1:0]  exp_done;
        bit          fin;
        logic [31:0] od;
        win = -1;
        fin = 1'b0;
        exp_done = 2'b00;
        if (!m_busy) begin
            if (pend[0] && pend[1]) win = (m_last == 0) ? 1 : 0;
            else if (pend[0])       win = 0;
            else if (pend[1])       win = 1;
        end
        chk("rr_ready", {ifm_req_ready, wt_req_ready}, {win == 1, win == 0});
        if (win >= 0 && pend_len[win] == 32'd0) exp_done[win] = 1'b1;
        chk("addr_valid", req_read_addr_valid, m_busy && m_addr_wait);
        if (m_busy && m_addr_wait)
            chk("addr_len", {req_read_addr, req_read_len}, {m_cur_addr, m_cur_len});
        if (m_busy && !m_addr_wait) begin
            chk("data_ready", req_read_data_ready, dready[m_owner]);
            chk("dout_valid", {ifm_dout_valid, wt_dout_valid},
                (m_owner == 1) ? {req_read_data_valid, 1'b0} : {1'b0, req_read_data_valid});
            if (req_read_data_valid && dready[m_owner]) begin
                od = (m_owner == 1) ? ifm_dout : wt_dout;
                chk("dout_data", od, m_cur_addr + m_beat);
                m_beat = m_beat + 32'd1;
                if (m_beat == m_cur_len) begin
                    exp_done[m_owner] = 1'b1;
                    fin = 1'b1;
                end
            end
        end else begin
            chk("idle_quiet", {req_read_data_ready, ifm_dout_valid, wt_dout_valid}, 3'b000);
        end
        chk("done", {ifm_done, wt_done}, exp_done);
        // memory environment follows the DUT handshakes
        if (req_read_data_valid && req_read_data_ready && mq.size() > 0) begin
            midx = midx + 32'd1;
            if (midx == mq[0].l) begin
                void'(mq.pop_front());
                midx = 32'd0;
            end
        end
        if (req_read_addr_valid && req_read_addr_ready) mq.push_back('{req_read_addr, req_read_len});
        if (m_busy && m_addr_wait && req_read_addr_ready) m_addr_wait = 1'b0;
        if (fin) begin
            m_busy = 1'b0;
            m_last = m_owner;
        end
        if (win >= 0) begin
            grants.push_back(win);
            pend[win] = 1'b0;
            if (pend_len[win] == 32'd0) begin
                m_last = win;
            end else begin
                m_busy = 1'b1; m_owner = win; m_addr_wait = 1'b1; m_beat = 32'd0;
                m_cur_addr = pend_addr[win]; m_cur_len = pend_len[win];
            end
        end
    endtask

    // gen: 0 = no new requests, 1 = both always requesting fixed bursts, 2 = random
    task automatic run_model(input int cycles, input int gen);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                if (!pend[p]) begin
                    if (gen == 1) begin
                        pend[p] = 1'b1;
                        pend_addr[p] = (p == 1) ? 32'h2000 : 32'h0;
                        pend_len[p]  = (p == 1) ? 32'd16 : 32'd4;
                    end else if (gen == 2 && $urandom_range(0, 2) == 0) begin
                        pend[p] = 1'b1;
                        pend_addr[p] = $urandom;
                        pend_len[p]  = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(1, 6));
                    end
                end
                dready[p] = (gen == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
            end
            wt_req_valid = pend[0]; wt_req_addr = pend_addr[0]; wt_req_len = pend_len[0];
            ifm_req_valid = pend[1]; ifm_req_addr = pend_addr[1]; ifm_req_len = pend_len[1];
            wt_dout_ready = dready[0];
            ifm_dout_ready = dready[1];
            req_read_addr_ready = (gen == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            if (mq.size() > 0) begin
                req_read_data_valid = (gen == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
                req_read_data = mq[0].a + midx;
            end else begin
                req_read_data_valid = 1'b0;
                req_read_data = $urandom;
            end
            #1;
            model_step();
        end
    endtask

    initial begin
        // Zero-length requests keep the arbiter in IDLE, so each row is one cycle
        tbl[0] = '{1'b1, 1'b1, 32'd0, 32'd0, 4'b1010};  // reset tie -> WT
        tbl[1] = '{1'b1, 1'b1, 32'd0, 32'd0, 4'b0101};  // tie -> IFM
        tbl[2] = '{1'b0, 1'b0, 32'd0, 32'd0, 4'b0000};
        tbl[3] = '{1'b0, 1'b1, 32'd0, 32'd0, 4'b0101};  // IFM alone
        tbl[4] = '{1'b1, 1'b1, 32'd0, 32'd0, 4'b1010};  // WT follows IFM zero-length
        tbl[5] = '{1'b1, 1'b0, 32'd0, 32'd0, 4'b1010};  // WT alone
        tbl[6] = '{1'b1, 1'b1, 32'd0, 32'd0, 4'b0101};
        tbl[7] = '{1'b0, 1'b1, 32'd0, 32'd3, 4'b0100};  // real burst: ready, no done

        rst = 1'b1;
        idle_inputs();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        req_read_data_valid = 1'b1;
        #1;
        chk("reset_outputs",
            {wt_req_ready, ifm_req_ready, wt_dout_valid, ifm_dout_valid, wt_done, ifm_done,
             req_read_addr_valid, req_read_data_ready, req_read_addr, req_read_len}, 96'd0);
        rst = 1'b0;
        req_read_data_valid = 1'b0;

        // Arbitration table
        for (int i = 0; i < 8; i++) begin
            wt_req_valid = tbl[i].wv;  wt_req_len = tbl[i].wl;  wt_req_addr = 32'h40 * i;
            ifm_req_valid = tbl[i].iv; ifm_req_len = tbl[i].il; ifm_req_addr = 32'h80 * i;
            #1;
            chk($sformatf("vec%0d", i),
                {wt_req_ready, ifm_req_ready, wt_done, ifm_done, req_read_addr_valid},
                {tbl[i].exp, 1'b0});
            @(negedge clk);
        end

        // WT alone, len 9 at 0x100, everything ready
        do_reset();
        wt_req_valid = 1'b1; wt_req_addr = 32'h100; wt_req_len = 32'd9; wt_dout_ready = 1'b1;
        req_read_addr_ready = 1'b1; req_read_data_valid = 1'b1; req_read_data = 32'hD000;
        #1;
        chk("a_accept", wt_req_ready, 1'b1);
        @(negedge clk);
        wt_req_valid = 1'b0;
        #1;
        chk("a_addr", {req_read_addr_valid, req_read_addr, req_read_len, req_read_data_ready},
            {1'b1, 32'h100, 32'd9, 1'b0});
        beats = 0; dones = 0; flag = 1'b0; vals_ok = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            #1;
            if (wt_dout_valid && req_read_data_ready) beats++;
            if (wt_done) begin dones++; vals_ok = (beats == 9); end
            if (ifm_dout_valid) flag = 1'b1;
        end
        chk("a_beats", beats, 9);
        chk("a_done", {dones[3:0], vals_ok}, {4'd1, 1'b1});
        chk("a_ifm_quiet", flag, 1'b0);

        // WT len 6 with consumer ready toggling 1,0,1,0...
        do_reset();
        wt_req_valid = 1'b1; wt_req_addr = 32'h40; wt_req_len = 32'd6; wt_dout_ready = 1'b1;
        req_read_addr_ready = 1'b1;
        @(negedge clk);
        wt_req_valid = 1'b0;
        beats = 0; done_at = -1; vals_ok = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            wt_dout_ready = (i % 2 == 0);
            req_read_data_valid = 1'b1;
            req_read_data = 32'(i);
            #1;
            if (i <= 10) chk("b_mirror", req_read_data_ready, wt_dout_ready);
            if (wt_dout_valid && wt_dout_ready) begin
                if (wt_dout != 32'(2 * beats)) vals_ok = 1'b0;
                beats++;
            end
            if (wt_done) done_at = i;
        end
        chk("b_beats", beats, 6);
        chk("b_done_cycle", done_at, 10);
        chk("b_values", vals_ok, 1'b1);

        // IFM len 2 with memory address stalled five cycles
        do_reset();
        ifm_req_valid = 1'b1; ifm_req_addr = 32'h3000; ifm_req_len = 32'd2; ifm_dout_ready = 1'b1;
        #1;
        chk("c_accept", ifm_req_ready, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            ifm_req_valid = 1'b0; ifm_req_addr = 32'hFFFF_0000 + 32'(i); ifm_req_len = 32'd7;
            req_read_addr_ready = (i == 5);
            #1;
            chk("c_addr_hold", {req_read_addr_valid, req_read_addr, req_read_len},
                {1'b1, 32'h3000, 32'd2});
        end
        @(negedge clk);
        req_read_addr_ready = 1'b0; req_read_data_valid = 1'b1; req_read_data = 32'hA;
        #1;
        chk("c_data_entry", {ifm_dout_valid, wt_dout_valid, ifm_done, req_read_addr_valid},
            4'b1000);
        @(negedge clk);
        #1;
        chk("c_done", {ifm_dout_valid, ifm_done}, 2'b11);
        @(negedge clk);
        #1;
        chk("c_idle", {ifm_dout_valid, req_read_data_ready, req_read_addr_valid, ifm_done}, 4'b0000);

        // Reset after three of nine WT beats
        do_reset();
        wt_req_valid = 1'b1; wt_req_addr = 32'h500; wt_req_len = 32'd9; wt_dout_ready = 1'b1;
        req_read_addr_ready = 1'b1;
        @(negedge clk);
        wt_req_valid = 1'b0;
        beats = 0; dones = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            req_read_data_valid = 1'b1;
            #1;
            if (wt_dout_valid && req_read_data_ready) beats++;
            if (wt_done) dones++;
        end
        chk("d_pre_beats", {beats[7:0], dones[7:0]}, {8'd3, 8'd0});
        @(negedge clk);
        rst = 1'b1;
        req_read_data_valid = 1'b0;
        #1;
        chk("d_rst_cycle_done", wt_done, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rst = 1'b0;
            req_read_data_valid = 1'b1;
            #1;
            chk("d_after_rst",
                {req_read_data_ready, wt_dout_valid, ifm_dout_valid, wt_done, ifm_done,
                 req_read_addr_valid, wt_req_ready, req_read_addr, req_read_len}, 96'd0);
        end

        // Both requesting continuously: WT len 4 @0x0, IFM len 16 @0x2000
        do_reset();
        run_model(60, 1);
        go = 8'hFF;
        for (int i = 0; i < 4; i++)
            if (i < grants.size()) go[7 - 2 * i -: 2] = 2'(grants[i]);
        chk("grant_order", go, 8'b00_01_00_01);

        // Randomized traffic, then drain
        run_model(1500, 2);
        run_model(300, 0);
        chk("drained", {m_busy, pend[0], pend[1], mq.size() != 0}, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
